// File: rtl/dmem_pkg.sv
// Shared types and constants for the pipelined data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ERR_ADDR = 0;
    localparam int ERR_PAR  = 1;

    // Ceiling log2, used for lane-bit and index-width math at elaboration.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables, registered read port and optional per-byte parity.
// Latency: read data and parity flag valid the cycle after en; writes commit on that same edge.
// Backpressure: none; the controller fires en at most once per access.
// Ports: clk; en/we/idx/wdata/be access strobe and operands; rdata/par_err registered read results.
// Optional feature: define DMEM_PARITY_EN to store and check one even-parity bit per byte.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = 9
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  par_err
);

    localparam int LANES = DATA_W / 8;

    // Not reset: contents survive rst_n.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < LANES; k++) begin
                    if (be[k]) begin
                        mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par [DEPTH];
    logic [LANES-1:0] rd_par;

    // Parity recomputed over every lane of the addressed word, not just enabled ones.
    always_comb begin
        rd_par = '0;
        for (int k = 0; k < LANES; k++) begin
            rd_par[k] = ^mem[idx][k*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int k = 0; k < LANES; k++) begin
                    if (be[k]) begin
                        par[idx][k] <= ^wdata[k*8 +: 8];
                    end
                end
            end else begin
                par_err <= |(rd_par ^ par[idx]);
            end
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_pipelined.sv
// Single-port data memory with valid/ready request and response channels, one access in flight.
// Latency: RSP_VALID rises LATENCY cycles after the request is accepted (LATENCY 1..15).
// Backpressure: REQ_READY is low from accept until the response is taken; the response holds while RSP_READY=0.
// Ports: clk, rst_n; REQ_* request channel (byte address, byte enables); RSP_* response channel (data, error bits).
// Optional feature: DMEM_PARITY_EN enables per-byte parity and RSP_ERR[1]; otherwise RSP_ERR[1] is 0.
module dmem_pipelined
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [ADDR_W-1:0]     REQ_ADDR,
    input  logic [DATA_W-1:0]     REQ_WDATA,
    input  logic [DATA_W/8-1:0]   REQ_BE,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic [1:0]            RSP_ERR
);

    localparam int LANES     = DATA_W / 8;
    localparam int LANE_BITS = clog2(LANES);
    localparam int IDX_W     = clog2(DEPTH);

    state_t              state;
    logic [3:0]          cnt;
    logic                lat_we;
    logic [IDX_W-1:0]    lat_idx;
    logic [DATA_W-1:0]   lat_wdata;
    logic [LANES-1:0]    lat_be;
    logic                lat_err;
    logic                rsp_vld;

    logic [ADDR_W-1:0]   idx_full;
    logic                req_err;
    logic                arr_en;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_par_err;

    // Mask form of the alignment test still works when there are no lane bits.
    assign idx_full = REQ_ADDR >> LANE_BITS;
    assign req_err  = ((REQ_ADDR & ADDR_W'(LANES - 1)) != '0) ||
                      (idx_full >= ADDR_W'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_err   <= 1'b0;
            rsp_vld   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        lat_we    <= REQ_WE;
                        lat_idx   <= idx_full[IDX_W-1:0];
                        lat_wdata <= REQ_WDATA;
                        lat_be    <= REQ_BE;
                        lat_err   <= req_err;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        rsp_vld <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        state   <= IDLE;
                        rsp_vld <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array fires on the last WAIT cycle; an asserted rst_n forces state to IDLE
    // and so blocks a write that has not yet reached its commit edge.
    assign arr_en = (state == WAIT) && (cnt == 4'd0) && !lat_err;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .en      (arr_en),
        .we      (lat_we),
        .idx     (lat_idx),
        .wdata   (lat_wdata),
        .be      (lat_be),
        .rdata   (arr_rdata),
        .par_err (arr_par_err)
    );

    // Response fields are held by registers that do not change while in RESP.
    assign REQ_READY = (state == IDLE);
    assign RSP_VALID = rsp_vld;
    assign RSP_RDATA = (rsp_vld && !lat_we && !lat_err) ? arr_rdata : '0;

    always_comb begin
        RSP_ERR           = 2'b00;
        RSP_ERR[ERR_ADDR] = rsp_vld && lat_err;
        RSP_ERR[ERR_PAR]  = rsp_vld && !lat_we && !lat_err && arr_par_err;
    end

endmodule
